serial_tx_engine: RTL
=====================

// Module: serial_tx_engine
// PURPOSE
//  Console-printer (KL8E teleprinter) transmit engine: 8N1/8N2 UART serializer with PDP-8 printer-flag semantics.
//  Sits directly downstream of the serial IOT decoder: consumes AC character, load, clear_flag, set_flag, clear.
//  Produces the tx line plus the printer flag used for the skip and interrupt logic. One-deep holding buffer allows back-to-back output.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock in Hz
//  BAUD       9600         line rate; DIVISOR = CLK_FREQ/BAUD clocks per bit (integer, >=2)
//  STOP_BITS  1            1 or 2 stop bits
// PORTS
//  clk         in   1     system clock, all logic on posedge
//  reset       in   1     asynchronous, active-low reset
//  clear       in   1     synchronous CAF/power clear, active-high
//  char        in   [0:11]  AC; char[4:11] is the byte, char[11] = LSB, sent first
//  load        in   1     level from decoder, may stay high many cycles; acted on at 0->1 edge only
//  clear_flag  in   1     level; clears printer flag while high
//  set_flag    in   1     level; sets printer flag (SPF)
//  tx          out  1     serial line, idle high
//  flag        out  1     printer flag: character finished (or SPF)
//  busy        out  1     shifter active or holding buffer full
// BEHAVIOUR
//  Reset (reset low, async): tx=1, flag=0, busy=0, state IDLE, holding empty, baud count 0, load edge detector primed (load_q=0).
//  clear (sync, has priority over every other input): same values as reset; a frame in progress is aborted and tx returns high the next cycle.
//  Load edge: load_q registers load; ld_evt = load & ~load_q. The byte is captured from char[4:11] on the ld_evt cycle.
//  ld_evt in IDLE: byte goes to the shifter, state START; tx falls 1 cycle after the clk edge that sees ld_evt.
//  ld_evt while busy: byte goes to the holding register (overwriting it if already full); busy stays 1.
//  States:
//   IDLE  tx=1; leave on ld_evt.
//   START tx=0 for DIVISOR cycles.
//   DATA  8 bits, LSB (char[11]) first, DIVISOR cycles each; 3-bit bit index wraps 7->0 on exit.
//   STOP  tx=1 for STOP_BITS*DIVISOR cycles.
//  At the end of STOP: done pulse (1 cycle).
//   If holding is full: holding moves to the shifter, holding empties, state START with no idle gap.
//   Else: IDLE.
//  Baud counter: counts 0..DIVISOR-1, reloads to 0 on every state entry; bit advance when count==DIVISOR-1; width $clog2(DIVISOR).
//  Frame length = (1+8+STOP_BITS)*DIVISOR cycles from the first tx-low cycle to the done pulse.
//  Flag: set by done or set_flag, cleared by clear_flag.
//   Set wins over clear in the same cycle, so a completion is never lost under a long clear_flag level.
//   TLS (load + clear_flag together) clears the flag and starts the frame.
//  busy = (state != IDLE) | holding_full; registered output, no combinational path from inputs.
//  The char value is ignored except on ld_evt cycles; char[0:3] is always ignored.
// TESTING
//  CLK_FREQ=16, BAUD=1 (DIVISOR=16) throughout.
//  1. Single char: load 0->1 with char=12'o0101 ->
//     tx low for 16 cycles, then bits 1,0,0,0,0,0,1,0 at 16 cycles each, then high;
//     flag=1 exactly 160 cycles after tx first falls.
//  2. Load level held 40 cycles and pulsed again while busy with char=12'o0102 ->
//     exactly two frames, 0x41 then 0x42, back-to-back (no idle gap); flag sets twice.
//  3. TLS: flag=1, assert load+clear_flag for 3 cycles ->
//     flag=0 the next cycle, frame starts; flag=1 again at the end of the frame.
//  4. clear_flag held high across the done cycle -> flag=1 (set wins); flag drops once clear_flag is re-asserted after done.
//  5. reset driven low mid-DATA -> tx=1, flag=0, busy=0 with no clock edge; after release, a new load sends a clean frame.
//  6. clear mid-STOP with holding full -> next cycle tx=1, busy=0, held byte discarded; set_flag pulse -> flag=1.

Source files
------------

// File: rtl/serial_tx_engine.sv
// serial_tx_engine: console-printer transmit engine.
// 8N1/8N2 serializer with PDP-8 printer-flag semantics and a one-deep
// holding buffer so software can queue the next character while the
// current one is still on the line.
module serial_tx_engine #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [0:11] char,
    input  logic        load,
    input  logic        clear_flag,
    input  logic        set_flag,
    output logic        tx,
    output logic        flag,
    output logic        busy
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       hold, hold_n;
    logic             hold_full, hold_full_n;
    logic             load_q, load_q_n;
    logic             flag_n, tx_n, busy_n;

    logic [7:0]       data_byte;
    logic             ld_evt;
    logic             bit_end;
    logic             done;
    logic             unused_char;

    // The upper AC bits carry no character data.
    assign data_byte   = char[4:11];
    assign unused_char = ^char[0:3];

    // The decoder holds load as a level; only its rising edge starts work.
    assign ld_evt  = load & ~load_q;
    assign bit_end = (cnt == CNT_LAST);
    assign done    = (state == STOP) && bit_end && (bit_idx == STOP_LAST);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves a latch.
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        load_q_n    = load;
        flag_n      = flag;
        tx_n        = 1'b1;
        busy_n      = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (ld_evt) begin
                    shift_n = data_byte;
                    state_n = START;
                end
            end
            START: begin
                cnt_n = cnt + 1'b1;
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                cnt_n = cnt + 1'b1;
                if (bit_end) begin
                    cnt_n     = '0;
                    shift_n   = {1'b0, shift[7:1]};
                    // Index wraps 7->0 on the way out to STOP.
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                cnt_n = cnt + 1'b1;
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_n = 3'd0;
                        if (hold_full) begin
                            // Queued character follows with no idle gap.
                            shift_n     = hold;
                            hold_full_n = 1'b0;
                            state_n     = START;
                        end else if (ld_evt) begin
                            // A load landing on the last stop cycle goes straight out.
                            shift_n = data_byte;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A load while the shifter is busy lands in (or overwrites) the holding buffer.
        if (ld_evt && (state != IDLE) && !(done && !hold_full)) begin
            hold_n      = data_byte;
            hold_full_n = 1'b1;
        end

        // Set beats clear so a completion is never lost under a long clear_flag.
        if (clear_flag) begin
            flag_n = 1'b0;
        end
        if (done || set_flag) begin
            flag_n = 1'b1;
        end

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE) || hold_full_n;

        // Power clear overrides everything, aborting any frame in flight.
        if (clear) begin
            state_n     = IDLE;
            cnt_n       = '0;
            bit_idx_n   = 3'd0;
            shift_n     = 8'h00;
            hold_n      = 8'h00;
            hold_full_n = 1'b0;
            load_q_n    = 1'b0;
            flag_n      = 1'b0;
            tx_n        = 1'b1;
            busy_n      = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            // NOTE: the shifter and holding bytes are reset too; they are tiny and it keeps sims X-free.
            shift     <= 8'h00;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            load_q    <= 1'b0;
            flag      <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            load_q    <= load_q_n;
            flag      <= flag_n;
            tx        <= tx_n;
            busy      <= busy_n;
        end
    end

endmodule
